// File: rtl/sqrt_seq_control_pkg.sv
// Shared definitions for the square-root sequencer and its datapath:
// FSM state encodings, iteration-counter width helper and default operand width.
package sqrt_seq_control_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ITER  = 3'd2,
    ST_STOP  = 3'd3,
    ST_VALID = 3'd4
  } state_t;

  // Counter width able to hold 0..NITER for a radicand of data_width bits.
  function automatic int cnt_w(input int data_width);
    return $clog2(data_width / 2 + 1);
  endfunction

endpackage

// File: rtl/sqrt_seq_control_if.sv
// Handshake bundle between the bus-facing wrapper (run/ack/abort) and the
// sequencer outputs that drive the sqrt datapath (start/step/iter/stop/done).
// master: wrapper/datapath side; slave: the sequencer itself.
interface sqrt_seq_control_if
  import sqrt_seq_control_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  localparam int CNT_W = cnt_w(DATA_WIDTH);

  logic             run;
  logic             ack;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             start;
  logic             step;
  logic [CNT_W-1:0] iter;
  logic             stop;
  logic             done;

  modport master (
    output run, ack, abort,
    input  ready, busy, start, step, iter, stop, done
  );

  modport slave (
    input  run, ack, abort,
    output ready, busy, start, step, iter, stop, done
  );

endinterface

// File: rtl/sqrt_seq_control_iter_counter.sv
// Iteration index counter for the sqrt sequencer: synchronous clear,
// count enable, and a terminal flag when the count equals LAST.
module sqrt_seq_control_iter_counter #(
  parameter int CNT_W = 5,
  parameter int LAST  = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Index register: clear wins over enable so a new run always starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(LAST));

endmodule

// File: rtl/sqrt_seq_control.sv
// Parametrised sequencer for the iterative square-root datapath.
// IDLE -> START -> ITER x NITER -> STOP -> (VALID | IDLE), NITER = DATA_WIDTH/2.
// HOLD_RESULT=1 holds done until ack; HOLD_RESULT=0 makes done a 1-cycle pulse.
// Optional feature macro: SQRT_CTRL_ABORT_EN (abort cancels START/ITER/STOP).
module sqrt_seq_control
  import sqrt_seq_control_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  sqrt_seq_control_if.slave  bus
);

  localparam int NITER = DATA_WIDTH / 2;
  localparam int CNT_W = cnt_w(DATA_WIDTH);

  state_t           state;
  state_t           state_d;
  logic             done_d;
  logic             abort_hit;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_last;
  logic [CNT_W-1:0] count;

  logic             start_r;
  logic             step_r;
  logic             stop_r;
  logic             busy_r;
  logic             done_r;

`ifdef SQRT_CTRL_ABORT_EN
  assign abort_hit = bus.abort &&
                     ((state == ST_START) || (state == ST_ITER) || (state == ST_STOP));
`else
  logic abort_unused;
  assign abort_unused = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; an abort overrides every normal transition of an active op.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    unique case (state)
      ST_IDLE:  if (bus.run) state_d = ST_START;
      ST_START: state_d = ST_ITER;
      ST_ITER:  if (cnt_last) state_d = ST_STOP;
      ST_STOP:  state_d = HOLD_RESULT ? ST_VALID : ST_IDLE;
      ST_VALID: if (bus.ack) state_d = bus.run ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d = ST_IDLE;
    end
    if (HOLD_RESULT) begin
      done_d = (state_d == ST_VALID);
    end else begin
      done_d = (state == ST_STOP) && !abort_hit;
    end
  end

  // Registered Moore strobes, loaded from the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_r <= 1'b0;
      step_r  <= 1'b0;
      stop_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      start_r <= (state_d == ST_START);
      step_r  <= (state_d == ST_ITER);
      stop_r  <= (state_d == ST_STOP);
      busy_r  <= (state_d == ST_START) || (state_d == ST_ITER) || (state_d == ST_STOP);
      done_r  <= done_d;
    end
  end

  // Index clears on entry to START and freezes at NITER-1 until the next op.
  assign cnt_clear = (state_d == ST_START);
  assign cnt_en    = (state == ST_ITER) && !cnt_last;

  sqrt_seq_control_iter_counter #(
    .CNT_W (CNT_W),
    .LAST  (NITER - 1)
  ) u_iter_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (count),
    .last    (cnt_last)
  );

  assign bus.ready = (state == ST_IDLE) || ((state == ST_VALID) && bus.ack);
  assign bus.busy  = busy_r;
  assign bus.start = start_r;
  assign bus.step  = step_r;
  assign bus.stop  = stop_r;
  assign bus.done  = done_r;
  assign bus.iter  = count;

endmodule

// File: tb/tb_sqrt_seq_control.sv
// Bench for sqrt_seq_control: DATA_WIDTH=32/HOLD_RESULT=1 and DATA_WIDTH=8/HOLD_RESULT=0
// instances, directed scenarios plus randomized run/ack/abort/reset traffic
// checked every cycle against a timeline model of each operation.
module tb_sqrt_seq_control;

`ifdef SQRT_CTRL_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] run   = 2'b00;
  logic [1:0] ack   = 2'b00;
  logic [1:0] abort = 2'b00;

  logic [1:0] o_ready, o_busy, o_start, o_step, o_stop, o_done;
  logic [7:0] o_iter0, o_iter1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_seq_control_if #(.DATA_WIDTH(32)) if32 ();
  sqrt_seq_control_if #(.DATA_WIDTH(8))  if8 ();

  sqrt_seq_control #(.DATA_WIDTH(32), .HOLD_RESULT(1'b1)) dut32 (
    .clock   (clk),
    .reset_n (rst_n[0]),
    .bus     (if32)
  );

  sqrt_seq_control #(.DATA_WIDTH(8), .HOLD_RESULT(1'b0)) dut8 (
    .clock   (clk),
    .reset_n (rst_n[1]),
    .bus     (if8)
  );

  assign if32.run   = run[0];
  assign if32.ack   = ack[0];
  assign if32.abort = abort[0];
  assign if8.run    = run[1];
  assign if8.ack    = ack[1];
  assign if8.abort  = abort[1];

  assign o_ready = {if8.ready, if32.ready};
  assign o_busy  = {if8.busy,  if32.busy};
  assign o_start = {if8.start, if32.start};
  assign o_step  = {if8.step,  if32.step};
  assign o_stop  = {if8.stop,  if32.stop};
  assign o_done  = {if8.done,  if32.done};
  assign o_iter0 = 8'(if32.iter);
  assign o_iter1 = 8'(if8.iter);

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] @%0t: got %b, want %b", name, idx, $time, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] @%0t: got %0d, want %0d", name, idx, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: t counts cycles since the op was accepted (0 = no op in flight);
  // start at t=1, steps at t=2..N+1 with index t-2, stop at t=N+2, then the result.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int N    = (g == 0) ? 16 : 4;
    localparam bit HOLD = (g == 0);
    int t      = 0;
    bit hold_v = 1'b0;
    bit pulse  = 1'b0;
    wire [7:0] it = (g == 0) ? o_iter0 : o_iter1;

    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        t      <= 0;
        hold_v <= 1'b0;
        pulse  <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (t != 0) begin
          if (ABORT_EN && abort[g]) begin
            t <= 0;
          end else if (t == N + 2) begin
            t <= 0;
            if (HOLD) hold_v <= 1'b1;
            else      pulse  <= 1'b1;
          end else begin
            t <= t + 1;
          end
        end else begin
          if (hold_v && ack[g]) hold_v <= 1'b0;
          if ((!hold_v || ack[g]) && run[g]) t <= 1;
        end
      end
    end

    always @(negedge clk) begin
      chk1("start", g, o_start[g], t == 1);
      chk1("step",  g, o_step[g],  (t >= 2) && (t <= N + 1));
      chk1("stop",  g, o_stop[g],  t == N + 2);
      chk1("busy",  g, o_busy[g],  t != 0);
      chk1("done",  g, o_done[g],  HOLD ? hold_v : pulse);
      chk1("ready", g, o_ready[g], (t == 0) && (!hold_v || ack[g]));
      if ((t >= 2) && (t <= N + 1)) chkn("iter_step", g, int'(it), t - 2);
      else if ((t == N + 2) || hold_v || pulse) chkn("iter_hold", g, int'(it), N - 1);
    end
  end

  // One complete op on the 32-bit instance with literal timing expectations.
  task automatic full_op32(input string tag);
    int nbusy;
    nbusy = 0;
    run[0] = 1'b1;
    tick();
    run[0] = 1'b0;
    chk1({tag, "_start"}, 0, o_start[0], 1'b1);
    nbusy += int'(o_busy[0]);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1({tag, "_step"}, 0, o_step[0], 1'b1);
      chkn({tag, "_iter"}, 0, int'(o_iter0), i);
      nbusy += int'(o_busy[0]);
    end
    tick();
    chk1({tag, "_stop"}, 0, o_stop[0], 1'b1);
    nbusy += int'(o_busy[0]);
    tick();
    chk1({tag, "_done"}, 0, o_done[0], 1'b1);
    chk1({tag, "_busy_off"}, 0, o_busy[0], 1'b0);
    chkn({tag, "_busy_cycles"}, 0, nbusy, 18);
  endtask

  initial begin
    int found, cnt, last_s, n_s, n_d;

    repeat (3) tick();
    rst_n = 2'b11;
    tick();
    chk1("rst_ready", 0, o_ready[0], 1'b1);
    chk1("rst_busy",  0, o_busy[0],  1'b0);
    chk1("rst_done",  0, o_done[0],  1'b0);
    chkn("rst_iter",  0, int'(o_iter0), 0);
    chk1("rst_ready", 1, o_ready[1], 1'b1);

    // T1: single op, exact timeline
    full_op32("t1");

    // T2: result held without ack; a run during VALID is ignored
    for (int i = 0; i < 10; i++) begin
      run[0] = (i == 4);
      tick();
      chk1("t2_done_held", 0, o_done[0],  1'b1);
      chk1("t2_ready_low", 0, o_ready[0], 1'b0);
      chk1("t2_no_start",  0, o_start[0], 1'b0);
    end
    ack[0] = 1'b1;
    run[0] = 1'b1;
    #1;
    chk1("t2_ready_ack", 0, o_ready[0], 1'b1);
    tick();
    chk1("t2_ack_run_start", 0, o_start[0], 1'b1);
    ack[0] = 1'b0;

    // T3: run kept high through the whole op and into VALID
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt += int'(o_start[0]);
    end
    chkn("t3_extra_starts", 0, cnt, 0);
    chk1("t3_done_held", 0, o_done[0], 1'b1);
    run[0] = 1'b0;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk1("t3_idle_ready", 0, o_ready[0], 1'b1);
    chk1("t3_done_clr",   0, o_done[0],  1'b0);

    // T4: reset in the middle of iteration 7
    run[0] = 1'b1;
    tick();
    run[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (o_step[0] && o_iter0 == 8'd7) found = 1;
      else tick();
    end
    chkn("t4_reach_iter7", 0, found, 1);
    rst_n[0] = 1'b0;
    #1;
    chk1("t4_start", 0, o_start[0], 1'b0);
    chk1("t4_step",  0, o_step[0],  1'b0);
    chk1("t4_stop",  0, o_stop[0],  1'b0);
    chk1("t4_done",  0, o_done[0],  1'b0);
    chk1("t4_busy",  0, o_busy[0],  1'b0);
    chkn("t4_iter",  0, int'(o_iter0), 0);
    tick();
    tick();
    rst_n[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      cnt += int'(o_stop[0] | o_done[0]);
    end
    chkn("t4_no_stop_done", 0, cnt, 0);
    full_op32("t4b");
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;

    // T5: abort at iteration 3 (completes normally when abort is not built in)
    run[0] = 1'b1;
    tick();
    run[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (o_step[0] && o_iter0 == 8'd3) found = 1;
      else tick();
    end
    chkn("t5_reach_iter3", 0, found, 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk1("t5_busy",  0, o_busy[0],  !ABORT_EN);
    chk1("t5_ready", 0, o_ready[0], ABORT_EN);
    chk1("t5_step",  0, o_step[0],  !ABORT_EN);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      cnt += int'(o_done[0] & ~cnt[0]);
    end
    chkn("t5_done_seen", 0, cnt, ABORT_EN ? 0 : 1);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;

    // T6: 8-bit pulse-mode instance with run held high
    run[1] = 1'b1;
    last_s = -1;
    n_s = 0;
    n_d = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (o_start[1]) begin
        if (last_s >= 0) chkn("t6_start_gap", 1, c - last_s, 7);
        last_s = c;
        n_s++;
      end
      n_d += int'(o_done[1]);
    end
    run[1] = 1'b0;
    chkn("t6_starts", 1, n_s, 9);
    chkn("t6_dones",  1, n_d, 8);
    repeat (8) tick();

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      run      = 2'($urandom_range(0, 3));
      ack      = 2'($urandom_range(0, 3));
      abort[0] = ($urandom_range(0, 15) == 0);
      abort[1] = ($urandom_range(0, 15) == 0);
      rst_n[1] = ($urandom_range(0, 599) != 0);
      tick();
    end
    run   = 2'b00;
    ack   = 2'b00;
    abort = 2'b00;
    rst_n = 2'b11;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

endmodule
